// File: rtl/fifo_rd_streamer_if.sv
// Handshake bundle for fifo_rd_streamer: the upstream FIFO read port plus the downstream
// valid/ready stream. The streamer takes the master modport; the environment takes slave.
interface fifo_rd_streamer_if #(
    parameter int unsigned no_bits = 32
);
    logic               fifo_cs;
    logic               fifo_rd_en;
    logic               fifo_empty;
    logic [no_bits-1:0] fifo_dout;
    logic               m_valid;
    logic               m_ready;
    logic [no_bits-1:0] m_data;

    modport master (
        output fifo_cs,
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_dout,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_cs,
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_dout,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Streams words out of a registered-output FIFO onto a valid/ready port via a 2-entry buffer.
// Optional macro FIFO_RD_STREAMER_CNT_EN adds a 16-bit wrapping words_out pop counter.
module fifo_rd_streamer #(
    parameter int unsigned no_bits = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    fifo_rd_streamer_if.master  bus,
    output logic                busy
`ifdef FIFO_RD_STREAMER_CNT_EN
    ,
    output logic [15:0]         words_out
`endif
);

    logic [1:0]         r_count;
    logic               r_inflight;
    logic [no_bits-1:0] r_head;
    logic [no_bits-1:0] r_tail;

    logic [1:0]         w_occ;
    logic               w_valid;
    logic               w_pop;
    logic               w_rd_en;

    assign w_occ   = r_count + {1'b0, r_inflight};
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & bus.m_ready;

    // A read may be issued into a full slot budget only if a pop frees a slot this edge.
    // Gated by reset so no read is requested while the block is held in reset.
    assign w_rd_en = reset & enable & ~bus.fifo_empty
                   & ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop));

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.fifo_cs    = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = r_head;
    assign busy           = w_valid | r_inflight;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= w_rd_en;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= bus.fifo_dout;
                    end else begin
                        r_tail <= bus.fifo_dout;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy unchanged, head advances.
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= bus.fifo_dout;
                    end else begin
                        r_head <= bus.fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FIFO_RD_STREAMER_CNT_EN
    logic [15:0] r_words;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_words <= 16'd0;
        end else if (w_pop) begin
            r_words <= r_words + 16'd1;
        end
    end

    assign words_out = r_words;
`endif

    a_count_max: assert property (@(posedge clk) disable iff (!reset) r_count <= 2'd2);
    a_occ_max: assert property (@(posedge clk) disable iff (!reset) w_occ <= 2'd2);
    a_no_rd_empty: assert property (@(posedge clk) disable iff (!reset)
        bus.fifo_empty |-> !w_rd_en);

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural registered-output FIFO model.
// Define FIFO_RD_STREAMER_CNT_EN for both bench and RTL to exercise the pop counter.
module tb_fifo_rd_streamer;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic busy;
`ifdef FIFO_RD_STREAMER_CNT_EN
    logic [15:0] words_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_rd_streamer_if #(.no_bits(32)) bus ();

    fifo_rd_streamer #(.no_bits(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus),
        .busy   (busy)
`ifdef FIFO_RD_STREAMER_CNT_EN
        ,
        .words_out (words_out)
`endif
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data appears one clock after an accepted read.
    logic [31:0] mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    initial bus.fifo_dout = 32'd0;
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [31:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.m_valid, busy, bus.fifo_rd_en, bus.fifo_cs} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.m_valid, busy, bus.fifo_rd_en, bus.fifo_cs});
        end
        n_tests++;
        if (bus.m_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h want 0", bus.m_data);
        end
`ifdef FIFO_RD_STREAMER_CNT_EN
        n_tests++;
        if (words_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_words_out: got %0h want 0", words_out);
        end
`endif
        reset = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [31:0] exp [4];
        exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'd4; exp[3] = 32'd8;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(exp[i]);
        enable = 1'b1;
        #1;
        n_tests++;
        if ({bus.fifo_rd_en, bus.fifo_cs} !== 2'b11) begin
            n_fail++;
            $display("FAIL stream_issue: got %b want 11", {bus.fifo_rd_en, bus.fifo_cs});
        end
        step();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_latency: m_valid got %b want 0", bus.m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL stream_word%0d: got v=%b d=%0h want v=1 d=%0h",
                         i, bus.m_valid, bus.m_data, exp[i]);
            end
        end
        step();
        n_tests++;
        if ({bus.m_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL stream_drained: got %b want 00", {bus.m_valid, busy});
        end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int reads = 0;
        int unstable = 0;
        logic [31:0] got [4];
        int ngot = 0;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(i);
        enable = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (bus.fifo_rd_en) reads++;
            if (bus.m_valid && bus.m_data !== 32'd1) unstable++;
            step();
        end
        n_tests++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL bp_reads: got %0d want 2", reads);
        end
        n_tests++;
        if ({bus.m_valid, bus.m_data} !== {1'b1, 32'd1} || unstable != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b d=%0h unstable=%0d want v=1 d=1 unstable=0",
                     bus.m_valid, bus.m_data, unstable);
        end
        bus.m_ready = 1'b1;
        #1;
        for (int c = 0; c < 20 && ngot < 4; c++) begin
            if (bus.m_valid) begin
                got[ngot] = bus.m_data;
                ngot++;
            end
            step();
        end
        n_tests++;
        if (ngot != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words want 4", ngot);
        end
        for (int i = 0; i < ngot; i++) begin
            n_tests++;
            if (got[i] !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %0h want %0h", i, got[i], i + 1);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: busy got %b want 0", busy);
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int reads = 0;
        logic [31:0] got [4];
        int ngot = 0;
        bus.m_ready = 1'b1;
        push(32'd5); push(32'd6); push(32'd7);
        enable = 1'b1;
        #1;
        n_tests++;
        if (bus.fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_issue: got %b want 1", bus.fifo_rd_en);
        end
        step();
        enable = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (bus.fifo_rd_en) reads++;
            if (bus.m_valid && ngot < 4) begin
                got[ngot] = bus.m_data;
                ngot++;
            end
            step();
        end
        n_tests++;
        if (reads != 0) begin
            n_fail++;
            $display("FAIL drop_reads: got %0d want 0", reads);
        end
        n_tests++;
        if (ngot != 1 || got[0] !== 32'd5) begin
            n_fail++;
            $display("FAIL drop_word: got n=%0d d=%0h want n=1 d=5", ngot, got[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got [2];
        int ngot = 0;
        // FIFO still holds 6 and 7 from the previous scenario.
        bus.m_ready = 1'b0;
        push(32'd8); push(32'd9);
        enable = 1'b1;
        for (int c = 0; c < 5; c++) step();
        n_tests++;
        if ({bus.m_valid, bus.m_data} !== {1'b1, 32'd6}) begin
            n_fail++;
            $display("FAIL rst_pre: got v=%b d=%0h want v=1 d=6", bus.m_valid, bus.m_data);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.m_valid, busy, bus.fifo_rd_en, bus.fifo_cs} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 0000",
                     {bus.m_valid, busy, bus.fifo_rd_en, bus.fifo_cs});
        end
        n_tests++;
        if (bus.m_data !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_data: got %0h want 0", bus.m_data);
        end
        step();
        step();
        reset = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        for (int c = 0; c < 10 && ngot < 2; c++) begin
            if (bus.m_valid) begin
                got[ngot] = bus.m_data;
                ngot++;
            end
            step();
        end
        n_tests++;
        if (ngot != 2 || got[0] !== 32'd8 || got[1] !== 32'd9) begin
            n_fail++;
            $display("FAIL rst_resume: got n=%0d %0h %0h want n=2 8 9", ngot, got[0], got[1]);
        end
        step();
    endtask

    task automatic test_empty();
        enable = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if ({bus.fifo_rd_en, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL empty_c%0d: rd_en/busy got %b want 00", c,
                         {bus.fifo_rd_en, busy});
            end
            step();
        end
    endtask

    task automatic test_throttle();
        logic [31:0] got [6];
        int ngot = 0;
        for (int i = 10; i < 16; i++) push(i);
        enable = 1'b1;
        for (int c = 0; c < 40 && ngot < 6; c++) begin
            bus.m_ready = (c % 3 != 2);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                got[ngot] = bus.m_data;
                ngot++;
            end
            step();
        end
        n_tests++;
        if (ngot != 6) begin
            n_fail++;
            $display("FAIL thr_count: got %0d want 6", ngot);
        end
        for (int i = 0; i < ngot; i++) begin
            n_tests++;
            if (got[i] !== 32'(10 + i)) begin
                n_fail++;
                $display("FAIL thr_word%0d: got %0h want %0h", i, got[i], 10 + i);
            end
        end
        bus.m_ready = 1'b1;
        enable = 1'b0;
        step();
    endtask

`ifdef FIFO_RD_STREAMER_CNT_EN
    task automatic test_cnt_wrap();
        int pops = 0;
        int pushed = 0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.m_ready = 1'b1;
        enable = 1'b1;
        #1;
        n_tests++;
        if (words_out !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_start: got %0h want 0", words_out);
        end
        for (int c = 0; c < 70000; c++) begin
            if (pushed < 65537 && (wr_ptr - rd_ptr) < 64) begin
                push(pushed);
                pushed++;
            end
            #1;
            if (bus.m_valid) pops++;
            if (pops == 65537) break;
            step();
        end
        step();
        n_tests++;
        if (pops != 65537 || words_out !== 16'd1) begin
            n_fail++;
            $display("FAIL cnt_wrap: pops=%0d words_out=%0h want pops=65537 words_out=1",
                     pops, words_out);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        step();
        test_reset();
        test_stream();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
        test_empty();
        test_throttle();
`ifdef FIFO_RD_STREAMER_CNT_EN
        test_cnt_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_streamer.md
FIFO_RD_STREAMER -- requirements
Module: fifo_rd_streamer

Interface
REQ-001 The block SHALL have parameter no_bits, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: 1 permits new FIFO reads.
REQ-005 The block SHALL have port fifo_cs, output, 1 bit: chip select to the upstream FIFO, always equal to fifo_rd_en.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: read request to the upstream FIFO.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-008 The block SHALL have port fifo_dout, input, no_bits: upstream FIFO registered read data, valid one clock after an accepted read.
REQ-009 The block SHALL have port m_valid, output, 1 bit: downstream word available.
REQ-010 The block SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-011 The block SHALL have port m_data, output, no_bits: downstream word.
REQ-012 The block SHALL have port busy, output, 1 bit: a word is buffered or a read is in flight.

Function
REQ-013 The block SHALL contain a 2-entry ordered output buffer (count 0..2) and a 1-bit in-flight flag.
REQ-014 A transfer SHALL occur on an edge where m_valid and m_ready are both 1 ("pop").
REQ-015 fifo_rd_en SHALL be combinational: enable AND NOT fifo_empty AND ((count + inflight) < 2 OR ((count + inflight) == 2 AND pop)).
REQ-016 inflight SHALL be set on an edge where fifo_rd_en is 1 and cleared on an edge where fifo_rd_en is 0.
REQ-017 On an edge where inflight is 1, fifo_dout SHALL be written into the buffer tail.
REQ-018 Latency: a read issued in cycle N SHALL make its word available as m_valid/m_data in cycle N+2 if the buffer is otherwise empty.
REQ-019 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain one word per clock.
REQ-020 m_data SHALL equal the buffer head and SHALL hold stable while m_valid is 1 and m_ready is 0.
REQ-021 m_valid SHALL equal (count != 0), and busy SHALL equal (count != 0) OR inflight.
REQ-022 Words SHALL leave in exact FIFO read order, with no loss or duplication.
REQ-023 A simultaneous capture and pop SHALL leave count unchanged and advance the head.
REQ-024 When enable falls, new reads SHALL stop immediately, while the in-flight word and buffered words SHALL still be delivered.
REQ-025 When fifo_empty is 1, fifo_rd_en SHALL be 0 regardless of the other conditions.

Reset
REQ-026 While reset is 0, the block SHALL asynchronously force count=0, inflight=0, m_valid=0, m_data=0, busy=0 and fifo_rd_en=fifo_cs=0.
REQ-027 Reset asserted mid-operation SHALL discard buffered and in-flight words, and operation SHALL resume from the empty state after release.

Configuration
REQ-028 With macro FIFO_RD_STREAMER_CNT_EN defined, the block SHALL add output words_out, 16 bits, that resets to 0, increments on each pop, and wraps 0xFFFF->0x0000.
REQ-029 Without FIFO_RD_STREAMER_CNT_EN, port words_out and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL cover: FIFO preloaded with 1,2,4,8 and m_ready=1 -> m_data 1,2,4,8 on consecutive cycles, the first 2 clocks after fifo_rd_en.
REQ-031 The bench SHALL cover: m_ready=0 with 4 words in the FIFO -> exactly 2 reads issued, m_valid=1, m_data=1 held stable; m_ready raised -> 1,2,3,4 delivered.
REQ-032 The bench SHALL cover: enable dropped the cycle after a read issue -> the in-flight word is delivered, with no further fifo_rd_en.
REQ-033 The bench SHALL cover: reset pulsed with count=2 -> m_valid=0 immediately; the next word delivered after release is the next FIFO word.
REQ-034 The bench SHALL cover: an empty FIFO with enable=1 -> fifo_rd_en=0 and busy=0 for 20 clocks.
REQ-035 The bench SHALL cover, with FIFO_RD_STREAMER_CNT_EN defined: 65537 pops -> words_out=1.
